// File: rtl/sonar_scheduler.sv
// sonar_scheduler: round-robin ranging scheduler for up to four HC-SR04 sensors.
// A microsecond tick paces a single FSM. The FSM triggers one sensor per slot,
// waits for its echo, measures the echo width, and publishes one result
// through a valid/ready handshake. It then holds off until the slot period
// has elapsed before moving to the next sensor.

`timescale 1ns/1ps

module sonar_scheduler #(
    parameter int CLKS_PER_US = 40,
    parameter int NUM_SENSORS = 4,
    parameter int TRIG_US     = 20,
    parameter int RISE_TO_US  = 1000,
    parameter int MAX_US      = 3552,
    parameter int SLOT_US     = 60000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic                   busy,
    output logic                   dist_valid,
    input  logic                   dist_ready,
    output logic [1:0]             dist_id,
    output logic [11:0]            dist_us,
    output logic                   dist_timeout
);

    localparam int               DIV_W     = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_US - 1);
    localparam logic [15:0]      TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0]      RISE_LAST = 16'(RISE_TO_US - 1);
    localparam logic [15:0]      SLOT_LAST = 16'(SLOT_US - 1);
    localparam logic [11:0]      MAX_COUNT = 12'(MAX_US);
    localparam logic [1:0]       LAST_PTR  = 2'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_PUBLISH,
        ST_HOLDOFF
    } state_t;

    state_t                 state_q,     state_d;
    logic [DIV_W-1:0]       div_q,       div_d;
    logic                   tick;
    logic [NUM_SENSORS-1:0] echo_meta_q, echo_meta_d;
    logic [NUM_SENSORS-1:0] echo_sync_q, echo_sync_d;
    logic                   echo_sel;
    logic [1:0]             ptr_q,       ptr_d;
    logic [15:0]            slot_q,      slot_d;
    logic [15:0]            rise_q,      rise_d;
    logic [11:0]            width_q,     width_d;
    logic                   seen_low_q,  seen_low_d;
    logic [NUM_SENSORS-1:0] trig_q,      trig_d;
    logic                   busy_q,      busy_d;
    logic                   valid_q,     valid_d;
    logic [1:0]             id_q,        id_d;
    logic [11:0]            us_q,        us_d;
    logic                   timeout_q,   timeout_d;

    // Free-running microsecond divider; tick marks its last count.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Two-stage echo synchronizer and selection of the sensor being served.
    always_comb begin
        echo_meta_d = echo;
        echo_sync_d = echo_meta_q;
        echo_sel    = 1'b0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (ptr_q == 2'(i)) begin
                echo_sel = echo_sync_q[i];
            end
        end
    end

    // Scheduler next-state logic, including the next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        slot_d     = slot_q;
        rise_d     = rise_q;
        width_d    = width_q;
        seen_low_d = seen_low_q;
        valid_d    = valid_q;
        id_d       = id_q;
        us_d       = us_q;
        timeout_d  = timeout_q;

        // Slot time saturates so a very long stall cannot wrap it back below the slot length.
        if (tick && (state_q != ST_IDLE) && (slot_q != 16'hFFFF)) begin
            slot_d = slot_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_d = ST_TRIG;
                    slot_d  = '0;
                end
            end

            ST_TRIG: begin
                if (tick && (slot_q == TRIG_LAST)) begin
                    state_d    = ST_WAIT_RISE;
                    rise_d     = '0;
                    seen_low_d = 1'b0;
                end
            end

            ST_WAIT_RISE: begin
                // A rise only counts once the echo has been seen low in this state.
                if (!echo_sel) begin
                    seen_low_d = 1'b1;
                end
                if (tick) begin
                    if (seen_low_q && echo_sel) begin
                        state_d = ST_MEASURE;
                        width_d = '0;
                    end else if (rise_q == RISE_LAST) begin
                        state_d   = ST_PUBLISH;
                        valid_d   = 1'b1;
                        id_d      = ptr_q;
                        us_d      = '0;
                        timeout_d = 1'b1;
                    end else begin
                        rise_d = rise_q + 16'd1;
                    end
                end
            end

            ST_MEASURE: begin
                if (tick) begin
                    if (!echo_sel) begin
                        state_d   = ST_PUBLISH;
                        valid_d   = 1'b1;
                        id_d      = ptr_q;
                        us_d      = width_q;
                        timeout_d = 1'b0;
                    end else if (width_q == MAX_COUNT - 12'd1) begin
                        state_d   = ST_PUBLISH;
                        width_d   = MAX_COUNT;
                        valid_d   = 1'b1;
                        id_d      = ptr_q;
                        us_d      = MAX_COUNT;
                        timeout_d = 1'b1;
                    end else begin
                        width_d = width_q + 12'd1;
                    end
                end
            end

            ST_PUBLISH: begin
                if (valid_q && dist_ready) begin
                    state_d = ST_HOLDOFF;
                    valid_d = 1'b0;
                end
            end

            ST_HOLDOFF: begin
                if (tick && (slot_q >= SLOT_LAST)) begin
                    ptr_d = (ptr_q == LAST_PTR) ? 2'd0 : ptr_q + 2'd1;
                    if (enable) begin
                        state_d = ST_TRIG;
                        slot_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        for (int i = 0; i < NUM_SENSORS; i++) begin
            trig_d[i] = (state_d == ST_TRIG) && (ptr_d == 2'(i));
        end
    end

    // State, counters, synchronizer and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            ptr_q       <= '0;
            slot_q      <= '0;
            rise_q      <= '0;
            width_q     <= '0;
            seen_low_q  <= 1'b0;
            trig_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            id_q        <= '0;
            us_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            echo_meta_q <= echo_meta_d;
            echo_sync_q <= echo_sync_d;
            ptr_q       <= ptr_d;
            slot_q      <= slot_d;
            rise_q      <= rise_d;
            width_q     <= width_d;
            seen_low_q  <= seen_low_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            us_q        <= us_d;
            timeout_q   <= timeout_d;
        end
    end

    assign trig         = trig_q;
    assign busy         = busy_q;
    assign dist_valid   = valid_q;
    assign dist_id      = id_q;
    assign dist_us      = us_q;
    assign dist_timeout = timeout_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb_sonar_scheduler: directed bench for sonar_scheduler with a result scoreboard.
// The stimulus pushes the expected result of each slot into a queue.
// A negedge monitor pops that queue on every accepted result. It also checks
// that results stay stable while stalled, and it checks the trig pulse shape.

`timescale 1ns/1ps

module tb_sonar_scheduler;

    localparam int CLKS = 4;
    localparam int NSEN = 2;
    localparam int TRIG = 2;
    localparam int RISE = 10;
    localparam int MAXU = 50;
    localparam int SLOT = 100;

    typedef struct {
        int id;
        int us;
        int to;
        int tol;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [NSEN-1:0] echo = '0;
    logic [NSEN-1:0] trig;
    logic            busy;
    logic            dist_valid;
    logic            dist_ready = 1'b1;
    logic [1:0]      dist_id;
    logic [11:0]     dist_us;
    logic            dist_timeout;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t expQ[$];

    sonar_scheduler #(
        .CLKS_PER_US (CLKS),
        .NUM_SENSORS (NSEN),
        .TRIG_US     (TRIG),
        .RISE_TO_US  (RISE),
        .MAX_US      (MAXU),
        .SLOT_US     (SLOT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .busy         (busy),
        .dist_valid   (dist_valid),
        .dist_ready   (dist_ready),
        .dist_id      (dist_id),
        .dist_us      (dist_us),
        .dist_timeout (dist_timeout)
    );

    // 100 MHz bench clock and a cycle counter used for all timing measurements.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run exceeded 2 ms, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
        checks++;
        if (actual < expected - tol || actual > expected + tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, expected - tol, expected + tol);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitTrig(input int idx, input logic lvl, input int budget, output int t);
        int n = 0;
        @(negedge clk);
        while (trig[idx] !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (trig[idx] !== lvl) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_trig%0d: level %0b not reached in %0d cycles", idx, lvl, budget);
        end
    endtask

    task automatic waitValid(input int budget, output int t);
        int n = 0;
        @(negedge clk);
        while (dist_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        if (dist_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_valid: no result within %0d cycles", budget);
        end
    endtask

    task automatic waitBusyLow(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: busy still %0b after %0d cycles", busy, budget);
        end
    endtask

    // Serve one slot: wait for the trigger, queue the expected result, then play the echo.
    task automatic applyStimulus(input int sensor, input int delayUs, input int widthUs,
                                 input int expUs, input int expTo, input int tol,
                                 output int riseT, output int fallT);
        exp_t e;
        waitTrig(sensor, 1'b1, 2000, riseT);
        e.id  = sensor;
        e.us  = expUs;
        e.to  = expTo;
        e.tol = tol;
        expQ.push_back(e);
        waitTrig(sensor, 1'b0, 100, fallT);
        if (widthUs > 0) begin
            stepCycles(delayUs * CLKS);
            echo[sensor] = 1'b1;
            stepCycles(widthUs * CLKS);
            echo[sensor] = 1'b0;
        end
    endtask

    logic       prevHold = 1'b0;
    logic [1:0] prevId;
    logic [11:0] prevUs;
    logic       prevTo;
    int         trigLen = 0;
    exp_t       got;

    // Monitor: scoreboard pops on accepted results, stall stability, trig pulse shape.
    always @(negedge clk) begin
        if (!reset) begin
            prevHold = 1'b0;
            trigLen  = 0;
        end else begin
            if (prevHold) begin
                checkOutput("stall_valid", dist_valid, 1, 0);
                checkOutput("stall_id", dist_id, prevId, 0);
                checkOutput("stall_us", dist_us, prevUs, 0);
                checkOutput("stall_timeout", dist_timeout, prevTo, 0);
            end
            prevHold = dist_valid && !dist_ready;
            prevId   = dist_id;
            prevUs   = dist_us;
            prevTo   = dist_timeout;

            if (dist_valid && dist_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: id=%0d us=%0d timeout=%0b with nothing expected",
                             dist_id, dist_us, dist_timeout);
                end else begin
                    got = expQ.pop_front();
                    checkOutput("result_id", dist_id, got.id, 0);
                    checkOutput("result_us", dist_us, got.us, got.tol);
                    checkOutput("result_timeout", dist_timeout, got.to, 0);
                end
            end

            if (trig != '0) begin
                trigLen++;
                checkOutput("trig_onehot", $countones(trig), 1, 0);
            end else if (trigLen != 0) begin
                checkOutput("trig_width", trigLen, CLKS * TRIG, 0);
                trigLen = 0;
            end
        end
    end

    int r1, r2, r3, r4, r5, r6, r7;
    int f1, f2, f3, f4, f5, f6, f7;
    int tv, tacc, trel;
    logic trigSeen;

    // Directed scenario sequence.
    initial begin
        stepCycles(3);
        checkOutput("reset_trig", trig, 0, 0);
        checkOutput("reset_busy", busy, 0, 0);
        checkOutput("reset_valid", dist_valid, 0, 0);
        checkOutput("reset_id", dist_id, 0, 0);
        checkOutput("reset_us", dist_us, 0, 0);
        checkOutput("reset_timeout", dist_timeout, 0, 0);

        reset = 1'b1;
        stepCycles(10);
        checkOutput("idle_without_enable", busy, 0, 0);

        enable = 1'b1;
        applyStimulus(0, 3, 30, 30, 0, 1, r1, f1);

        applyStimulus(1, 0, 0, 0, 1, 0, r2, f2);
        waitValid(100, tv);
        checkOutput("rise_timeout_latency", tv - f2, RISE * CLKS, 0);
        checkOutput("slot_period_1", r2 - r1, SLOT * CLKS, 0);

        applyStimulus(0, 3, 80, MAXU, 1, 0, r3, f3);
        checkOutput("slot_period_2", r3 - r2, SLOT * CLKS, 0);

        dist_ready = 1'b0;
        applyStimulus(1, 2, 10, 10, 0, 1, r4, f4);
        checkOutput("slot_period_3", r4 - r3, SLOT * CLKS, 0);
        waitValid(200, tv);
        trigSeen = 1'b0;
        for (int i = 0; i < 150 * CLKS; i++) begin
            stepCycles(1);
            if (trig != '0) trigSeen = 1'b1;
        end
        checkOutput("no_trig_during_stall", trigSeen, 0, 0);
        dist_ready = 1'b1;
        @(negedge clk);
        tacc = cyc + 1;
        waitTrig(0, 1'b1, 20, r5);
        checkOutput("restart_after_accept", r5 - tacc, 1 + (CLKS - 1) / 2, (CLKS - 1) / 2);

        begin
            exp_t e;
            e.id = 0; e.us = 0; e.to = 1; e.tol = 0;
            expQ.push_back(e);
        end
        stepCycles(1);
        echo[0] = 1'b1;
        waitTrig(0, 1'b0, 100, f5);
        stepCycles(3 * CLKS);
        echo[1] = 1'b1;
        stepCycles(5 * CLKS);
        echo[1] = 1'b0;
        waitValid(200, tv);
        checkOutput("held_echo_timeout_latency", tv - f5, RISE * CLKS, 0);
        stepCycles(1);
        echo[0] = 1'b0;

        waitTrig(1, 1'b1, 2000, r6);
        waitTrig(1, 1'b0, 100, f6);
        stepCycles(3 * CLKS);
        echo[1] = 1'b1;
        stepCycles(5 * CLKS);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_busy", busy, 0, 0);
        checkOutput("async_reset_trig", trig, 0, 0);
        checkOutput("async_reset_valid", dist_valid, 0, 0);
        echo[1] = 1'b0;
        stepCycles(2);
        reset = 1'b1;
        trel = cyc;
        waitTrig(0, 1'b1, 20, r7);
        checkOutput("first_trig_after_reset", r7 - trel, CLKS, 0);

        begin
            exp_t e;
            e.id = 0; e.us = 20; e.to = 0; e.tol = 1;
            expQ.push_back(e);
        end
        waitTrig(0, 1'b0, 100, f7);
        enable = 1'b0;
        stepCycles(3 * CLKS);
        echo[0] = 1'b1;
        stepCycles(20 * CLKS);
        echo[0] = 1'b0;
        waitBusyLow(SLOT * CLKS * 2);
        checkOutput("scoreboard_drained", expQ.size(), 0, 0);
        stepCycles(10 * CLKS);
        checkOutput("stays_idle_busy", busy, 0, 0);
        checkOutput("stays_idle_trig", trig, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sonar_scheduler.md
SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameters SHALL be the following.
- CLKS_PER_US, 40, clk cycles per 1 us tick (40 MHz clk).
- NUM_SENSORS, 4, HC-SR04 sensors sharing the scheduler (2..4).
- TRIG_US, 20, trig pulse width in ticks.
- RISE_TO_US, 1000, max ticks from trig fall to echo rise.
- MAX_US, 3552, echo width cap in ticks (2 ft range).
- SLOT_US, 60000, ticks from trig rise to the next sensor's trig rise.

REQ-002 Ports SHALL be the following (clock and reset first).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run the round-robin ranging schedule.
- echo  in  NUM_SENSORS  raw echo pins, asynchronous.
- trig  out  NUM_SENSORS  trigger pins, at most one high at a time.
- busy  out  1  high when state is not IDLE.
- dist_valid  out  1  result available.
- dist_ready  in  1  consumer accepts the result.
- dist_id  out  2  sensor index of the result.
- dist_us  out  12  echo width in us.
- dist_timeout  out  1  result is a timeout or saturation.

Function
REQ-003 A tick SHALL pulse for one clk when the divider reaches CLKS_PER_US-1; the divider then wraps to 0 and runs freely while out of reset.
REQ-004 Each echo bit SHALL pass through a 2-flop synchronizer; all echo decisions SHALL use synchronized values only.
REQ-005 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, PUBLISH and HOLDOFF; transitions other than IDLE exit SHALL occur on ticks.
REQ-006 IDLE SHALL go to TRIG on the first tick with enable=1, serving the sensor at pointer ptr; the slot counter SHALL clear to 0.
REQ-007 The 16-bit slot counter SHALL increment on every tick outside IDLE.
REQ-008 In TRIG, trig[ptr] SHALL be high for exactly TRIG_US ticks, then the FSM SHALL enter WAIT_RISE.
REQ-009 WAIT_RISE SHALL require a low-to-high edge of echo[ptr].
- An echo already high on entry SHALL NOT count as a rise.
- On a rise, go to MEASURE with the width counter at 0.
- After RISE_TO_US ticks with no rise, go to PUBLISH with dist_us=0 and dist_timeout=1.
REQ-010 MEASURE SHALL increment the 12-bit width counter once per tick while echo[ptr] is high.
- When echo falls, go to PUBLISH with dist_us=count and dist_timeout=0.
- If the count reaches MAX_US, go to PUBLISH with dist_us=MAX_US and dist_timeout=1, without waiting for the fall.
REQ-011 In PUBLISH, dist_valid SHALL be 1, with dist_id=ptr, dist_us and dist_timeout held stable until a clk edge with dist_valid and dist_ready both 1.
REQ-012 After that accepting edge, dist_valid SHALL be 0 and the FSM SHALL enter HOLDOFF; the slot counter keeps running during PUBLISH.
REQ-013 HOLDOFF SHALL end on the tick where the slot counter is at or above SLOT_US-1.
- ptr SHALL advance modulo NUM_SENSORS.
- If enable=1, go to TRIG and clear the slot counter; otherwise go to IDLE.
- If PUBLISH overran SLOT_US, the next TRIG SHALL start on the first tick after acceptance (stall, never drop).
REQ-014 Deasserting enable mid-slot SHALL NOT abort the slot; the result SHALL still be published.
REQ-015 Echo activity on sensors other than ptr SHALL be ignored.
REQ-016 trig SHALL be driven only in TRIG and SHALL be registered (glitch-free).

Reset
REQ-017 While reset=0, the block SHALL hold the following values.
- FSM in IDLE; ptr, divider, slot counter and width counter at 0.
- trig=0, busy=0, dist_valid=0, dist_id=0, dist_us=0, dist_timeout=0.
- Synchronizer flops at 0.
REQ-018 Reset asserted mid-operation SHALL take effect immediately; any pending result is discarded and trig drops without waiting for a clk edge.

Verification (CLKS_PER_US=4, NUM_SENSORS=2, TRIG_US=2, RISE_TO_US=10, MAX_US=50, SLOT_US=100)
REQ-019 enable=1; sensor 0 echo rises 3 us after trig falls and stays high 30 us; dist_ready=1 -> trig[0] high 8 clk; dist_id=0, dist_us=30±1, dist_timeout=0.
REQ-020 Sensor 1 echo never rises -> dist_id=1, dist_us=0, dist_timeout=1, published 10 ticks after trig fall.
REQ-021 Sensor 0 echo high for 80 us -> dist_us=50, dist_timeout=1; the next trig rise occurs 100 ticks after the previous one.
REQ-022 dist_ready=0 for 150 us during PUBLISH -> dist_valid and data stable throughout; no trig until acceptance; next trig on the first tick after acceptance.
REQ-023 Echo held high before WAIT_RISE, and an echo pulse on the non-selected sensor -> neither is measured; timeout reported.
REQ-024 Reset pulsed low during MEASURE -> trig=0 and dist_valid=0 asynchronously; after release, ptr=0 and first trig on the first tick.
